// File: rtl/kfpga_config_loader.sv
// rtl/kfpga_config_loader.sv - bitstream loader driving the kFPGA serial configuration chain
// Words arrive over valid/ready, are shifted MSB-first onto the chain, then an XOR checksum is verified.
module kfpga_config_loader #(
   parameter int WORD_WIDTH   = 32,
   parameter int CHAIN_LENGTH = 4096,
   parameter int CLEAR_CYCLES = 4,
   parameter int COUNT_WIDTH  = 16
) (
   input  logic                   i_clock,
   input  logic                   i_nreset,
   input  logic                   i_start,
   input  logic                   i_abort,
   input  logic [WORD_WIDTH-1:0]  i_word_in,
   input  logic                   i_word_valid,
   output logic                   o_word_ready,
   output logic                   o_cfg_data,
   output logic                   o_cfg_enable,
   output logic                   o_cfg_nreset,
   output logic                   o_busy,
   output logic                   o_done,
   output logic                   o_error,
   output logic [COUNT_WIDTH-1:0] o_bits_loaded
);

   localparam int SCW = $clog2(WORD_WIDTH + 1);
   localparam int CCW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
   localparam logic [CCW-1:0]         LP_CLR_LAST   = CCW'(CLEAR_CYCLES - 1);
   localparam logic [COUNT_WIDTH-1:0] LP_CHAIN      = COUNT_WIDTH'(CHAIN_LENGTH);
   localparam logic [COUNT_WIDTH-1:0] LP_CHAIN_LAST = COUNT_WIDTH'(CHAIN_LENGTH - 1);
   localparam logic [COUNT_WIDTH-1:0] LP_WORD       = COUNT_WIDTH'(WORD_WIDTH);
   localparam logic [SCW-1:0]         LP_WORD_BITS  = SCW'(WORD_WIDTH);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_LOAD, S_CHECK, S_DONE, S_ERROR
   } state_t;

   state_t r_state, w_state_nxt;

   logic [WORD_WIDTH-1:0]  r_sreg, w_sreg_nxt;
   logic [SCW-1:0]         r_sreg_cnt, w_sreg_cnt_nxt;
   logic [WORD_WIDTH-1:0]  r_acc, w_acc_nxt;
   logic [COUNT_WIDTH-1:0] r_bits_loaded, w_bits_nxt;
   logic [CCW-1:0]         r_clear_cnt, w_clear_cnt_nxt;
   logic                   r_cfg_data, w_cfg_data_nxt;
   logic                   r_cfg_enable, w_cfg_enable_nxt;
   logic                   r_word_ready, w_word_ready_nxt;

   logic                   w_busy;
   logic                   w_start;
   logic                   w_abort;
   logic                   w_accept;
   logic                   w_shift;
   logic [COUNT_WIDTH-1:0] w_remain;
   logic [SCW-1:0]         w_take;

   assign w_busy   = (r_state == S_CLEAR) || (r_state == S_LOAD) || (r_state == S_CHECK);
   assign w_start  = !w_busy && i_start;
   assign w_abort  = w_busy && i_abort;
   assign w_accept = i_word_valid && r_word_ready;
   assign w_shift  = (r_state == S_LOAD) && (r_sreg_cnt != '0);
   // Only the bits still owed to the chain are queued; the tail of a final partial word is dropped.
   assign w_remain = LP_CHAIN - r_bits_loaded;
   assign w_take   = (w_remain >= LP_WORD) ? LP_WORD_BITS : SCW'(w_remain);

   always_ff @(posedge i_clock) begin
      if (!i_nreset) r_state <= S_IDLE;
      else           r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_DONE, S_ERROR: if (i_start) w_state_nxt = S_CLEAR;
         S_CLEAR: begin
            if (i_abort)                          w_state_nxt = S_ERROR;
            else if (r_clear_cnt == LP_CLR_LAST)  w_state_nxt = S_LOAD;
         end
         S_LOAD: begin
            if (i_abort)                                         w_state_nxt = S_ERROR;
            else if (w_shift && (r_bits_loaded == LP_CHAIN_LAST)) w_state_nxt = S_CHECK;
         end
         S_CHECK: begin
            if (i_abort)       w_state_nxt = S_ERROR;
            else if (w_accept) w_state_nxt = (i_word_in == r_acc) ? S_DONE : S_ERROR;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_sreg_nxt       = r_sreg;
      w_sreg_cnt_nxt   = r_sreg_cnt;
      w_acc_nxt        = r_acc;
      w_bits_nxt       = r_bits_loaded;
      w_clear_cnt_nxt  = r_clear_cnt;
      w_cfg_data_nxt   = r_cfg_data;
      w_cfg_enable_nxt = 1'b0;
      if (w_start) begin
         w_sreg_nxt      = '0;
         w_sreg_cnt_nxt  = '0;
         w_acc_nxt       = '0;
         w_bits_nxt      = '0;
         w_clear_cnt_nxt = '0;
      end else if (w_abort) begin
         w_sreg_nxt     = '0;
         w_sreg_cnt_nxt = '0;
      end else begin
         if (r_state == S_CLEAR) w_clear_cnt_nxt = r_clear_cnt + 1'b1;
         if (w_shift) begin
            w_cfg_data_nxt   = r_sreg[WORD_WIDTH-1];
            w_cfg_enable_nxt = 1'b1;
            w_sreg_nxt       = r_sreg << 1;
            w_sreg_cnt_nxt   = r_sreg_cnt - 1'b1;
            w_bits_nxt       = r_bits_loaded + 1'b1;
         end else if (w_accept && (r_state == S_LOAD)) begin
            w_sreg_nxt     = i_word_in;
            w_sreg_cnt_nxt = w_take;
            w_acc_nxt      = r_acc ^ i_word_in;
         end
      end
      // Ready is registered from the upcoming state so it never depends combinationally on valid.
      w_word_ready_nxt = (w_state_nxt == S_CHECK) ||
                         ((w_state_nxt == S_LOAD) && (w_sreg_cnt_nxt == '0));
   end

   always_ff @(posedge i_clock) begin
      if (!i_nreset) begin
         r_sreg        <= '0;
         r_sreg_cnt    <= '0;
         r_acc         <= '0;
         r_bits_loaded <= '0;
         r_clear_cnt   <= '0;
         r_cfg_data    <= 1'b0;
         r_cfg_enable  <= 1'b0;
         r_word_ready  <= 1'b0;
      end else begin
         r_sreg        <= w_sreg_nxt;
         r_sreg_cnt    <= w_sreg_cnt_nxt;
         r_acc         <= w_acc_nxt;
         r_bits_loaded <= w_bits_nxt;
         r_clear_cnt   <= w_clear_cnt_nxt;
         r_cfg_data    <= w_cfg_data_nxt;
         r_cfg_enable  <= w_cfg_enable_nxt;
         r_word_ready  <= w_word_ready_nxt;
      end
   end

   assign o_word_ready  = r_word_ready;
   assign o_cfg_data    = r_cfg_data;
   assign o_cfg_enable  = r_cfg_enable;
   assign o_cfg_nreset  = (r_state != S_CLEAR);
   assign o_busy        = w_busy;
   assign o_done        = (r_state == S_DONE);
   assign o_error       = (r_state == S_ERROR);
   assign o_bits_loaded = r_bits_loaded;

endmodule
